// File: rtl/lcd_pkg.sv
// lcd_pkg: shared encodings and state types for the LCD message writer and its panel driver.
package lcd_pkg;

    localparam logic [1:0] OPS_CMD   = 2'd0;
    localparam logic [1:0] OPS_DATA  = 2'd1;
    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_LINE2 = 8'hC0;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ISSUE,
        WAIT_ACK,
        WAIT_RDY,
        NEXT,
        FINISH
    } state_e;

    typedef enum logic [1:0] {
        D_IDLE,
        D_SETUP,
        D_E_HI,
        D_HOLD
    } drv_state_e;

endpackage

// File: rtl/lcd16x2.sv
// lcd16x2: single-transaction HD44780-style bus driver; rdy_o high when a new write may be accepted.
module lcd16x2
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int E_CYC     = 4,
    parameter int HOLD_CYC  = 6
)(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] data_i,
    input  logic [1:0] ops_i,
    input  logic       enb_i,
    output logic       rdy_o,
    output logic       lcd_rs_o,
    output logic       lcd_e_o,
    output logic [7:0] lcd_data_o
);

    localparam int CW = 8;

    drv_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rs_q, rs_d;
    logic [7:0]    dat_q, dat_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= D_IDLE;
            cnt_q   <= '0;
            rs_q    <= 1'b0;
            dat_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            dat_q   <= dat_d;
        end
    end

    // Bus is latched at accept and held through setup, E-high and hold phases.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rs_d    = rs_q;
        dat_d   = dat_q;
        case (state_q)
            D_IDLE: if (enb_i) begin
                rs_d    = (ops_i == OPS_DATA);
                dat_d   = data_i;
                cnt_d   = CW'(SETUP_CYC - 1);
                state_d = D_SETUP;
            end
            D_SETUP: if (cnt_q == '0) begin
                cnt_d   = CW'(E_CYC - 1);
                state_d = D_E_HI;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            D_E_HI: if (cnt_q == '0) begin
                cnt_d   = CW'(HOLD_CYC - 1);
                state_d = D_HOLD;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            D_HOLD: if (cnt_q == '0) begin
                state_d = D_IDLE;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            default: state_d = D_IDLE;
        endcase
    end

    assign rdy_o      = (state_q == D_IDLE);
    assign lcd_e_o    = (state_q == D_E_HI);
    assign lcd_rs_o   = rs_q;
    assign lcd_data_o = dat_q;

endmodule

// File: rtl/lcd_msg_writer.sv
// lcd_msg_writer: prints a buffered ASCII message through lcd16x2, with optional clear
// and a single jump to line 2 after LINE_LEN characters.
module lcd_msg_writer
    import lcd_pkg::*;
#(
    parameter int MSG_LEN        = 32,
    parameter int LINE_LEN       = 16,
    parameter bit CLEAR_ON_START = 1'b1,
    localparam int AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1,
    localparam int LW = $clog2(MSG_LEN) + 1
)(
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          msg_we_i,
    input  logic [AW-1:0] msg_addr_i,
    input  logic [7:0]    msg_data_i,
    input  logic [LW-1:0] len_i,
    input  logic          clr_i,
    input  logic          start_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          lcd_rs_o,
    output logic          lcd_e_o,
    output logic [7:0]    lcd_data_o
);

    state_e        state_q, state_d;
    logic [LW-1:0] idx_q, idx_d;
    logic [LW-1:0] len_q, len_d;
    logic          line2_q, line2_d;
    logic [7:0]    data_q, data_d;
    logic [1:0]    ops_q, ops_d;
    logic          enb_q, enb_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          rdy;
    logic [LW-1:0] len_sat;
    logic [LW-1:0] idx_inc;
    logic [7:0]    msg_buf [MSG_LEN];

    assign len_sat = (len_i > LW'(MSG_LEN)) ? LW'(MSG_LEN) : len_i;
    assign idx_inc = idx_q + LW'(1);

    // Writes only land while idle, so the message is frozen for the whole print.
    always_ff @(posedge clk_i) begin
        if (msg_we_i && state_q == IDLE)
            msg_buf[msg_addr_i] <= msg_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            line2_q <= 1'b0;
            data_q  <= 8'h00;
            ops_q   <= OPS_CMD;
            enb_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            line2_q <= line2_d;
            data_q  <= data_d;
            ops_q   <= ops_d;
            enb_q   <= enb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // CLEAR issues whichever command is pending: clear-display, or the line-2 jump when line2_q is set.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        line2_d = line2_q;
        data_d  = data_q;
        ops_d   = ops_q;
        enb_d   = enb_q;
        case (state_q)
            IDLE: if (start_i) begin
                len_d   = len_sat;
                idx_d   = '0;
                line2_d = 1'b0;
                state_d = (clr_i && CLEAR_ON_START) ? CLEAR : (len_sat == '0) ? FINISH : ISSUE;
            end
            CLEAR: if (rdy) begin
                data_d  = line2_q ? CMD_LINE2 : CMD_CLEAR;
                ops_d   = OPS_CMD;
                enb_d   = 1'b1;
                state_d = WAIT_ACK;
            end
            ISSUE: if (rdy) begin
                data_d  = msg_buf[idx_q[AW-1:0]];
                ops_d   = OPS_DATA;
                enb_d   = 1'b1;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: if (!rdy) begin
                enb_d   = 1'b0;
                state_d = WAIT_RDY;
            end
            WAIT_RDY: if (rdy) begin
                state_d = (ops_q == OPS_DATA) ? NEXT : (!line2_q && len_q == '0) ? FINISH : ISSUE;
            end
            NEXT: begin
                idx_d = idx_inc;
                if (idx_inc == len_q) begin
                    state_d = FINISH;
                end else if (LINE_LEN < MSG_LEN && idx_inc == LW'(LINE_LEN)) begin
                    line2_d = 1'b1;
                    state_d = CLEAR;
                end else begin
                    state_d = ISSUE;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy_d = (state_d != IDLE);
    assign done_d = (state_q == FINISH);
    assign busy_o = busy_q;
    assign done_o = done_q;

    lcd16x2 u_drv (
        .clk_i      (clk_i),
        .rst_i      (~rst_ni),
        .data_i     (data_q),
        .ops_i      (ops_q),
        .enb_i      (enb_q),
        .rdy_o      (rdy),
        .lcd_rs_o   (lcd_rs_o),
        .lcd_e_o    (lcd_e_o),
        .lcd_data_o (lcd_data_o)
    );

endmodule

// File: tb/tb_lcd_msg_writer.sv
// tb_lcd_msg_writer: directed bench; panel transactions are captured on each falling edge of lcd_e_o.
module tb_lcd_msg_writer;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       msg_we_i;
    logic [4:0] msg_addr_i;
    logic [7:0] msg_data_i;
    logic [5:0] len_i;
    logic       clr_i;
    logic       start_i;
    logic       busy_o;
    logic       done_o;
    logic       lcd_rs_o;
    logic       lcd_e_o;
    logic [7:0] lcd_data_o;

    int         checks = 0;
    int         fails  = 0;
    int         done_cnt = 0;
    logic [8:0] tq [$];

    always #5 clk = ~clk;

    lcd_msg_writer dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .msg_we_i   (msg_we_i),
        .msg_addr_i (msg_addr_i),
        .msg_data_i (msg_data_i),
        .len_i      (len_i),
        .clr_i      (clr_i),
        .start_i    (start_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .lcd_rs_o   (lcd_rs_o),
        .lcd_e_o    (lcd_e_o),
        .lcd_data_o (lcd_data_o)
    );

    always @(negedge lcd_e_o) if (rst_ni === 1'b1) tq.push_back({lcd_rs_o, lcd_data_o});
    always @(posedge clk) if (done_o === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_char(input int addr, input logic [7:0] ch);
        msg_we_i   = 1'b1;
        msg_addr_i = 5'(addr);
        msg_data_i = ch;
        @(negedge clk);
        msg_we_i = 1'b0;
    endtask

    task automatic start(input int len, input logic clr);
        start_i = 1'b1;
        len_i   = 6'(len);
        clr_i   = clr;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_o !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, 32'(done_o), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_trans(input int base, input int cnt);
        int n = 0;
        while (tq.size() - base < cnt && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("wait_trans", 32'(tq.size() - base >= cnt), 32'd1);
    endtask

    initial begin
        string hello = "HELLO WORLD";
        string pat   = "ABCDEFGHIJKLMNOPQRSTUVWXYZ012345";
        int    b;
        int    d;
        rst_ni = 1'b0; msg_we_i = 1'b0; msg_addr_i = '0; msg_data_i = '0;
        len_i = '0; clr_i = 1'b0; start_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_e", 32'(lcd_e_o), 32'd0);
        check("rst_data", 32'(lcd_data_o), 32'h00);
        rst_ni = 1'b1;
        @(negedge clk);

        // HELLO WORLD, no clear
        for (int i = 0; i < 11; i++) write_char(i, hello[i]);
        b = tq.size(); d = done_cnt;
        start(11, 1'b0);
        check("hello_busy", 32'(busy_o), 32'd1);
        wait_done("hello", 2000);
        check("hello_count", 32'(tq.size() - b), 32'd11);
        for (int i = 0; i < 11; i++)
            check($sformatf("hello_ch%0d", i), 32'(tq[b + i]), 32'({1'b1, hello[i]}));
        check("hello_done_once", 32'(done_cnt - d), 32'd1);
        check("hello_busy_end", 32'(busy_o), 32'd0);

        // 20 chars with clear: cmd 01, 16 data, cmd C0, 4 data
        for (int i = 0; i < 32; i++) write_char(i, pat[i]);
        b = tq.size(); d = done_cnt;
        start(20, 1'b1);
        wait_done("l20", 3000);
        check("l20_count", 32'(tq.size() - b), 32'd22);
        for (int i = 0; i < 22; i++) begin
            logic [8:0] e;
            e = (i == 0) ? 9'h001 : (i == 17) ? 9'h0C0 : (i < 17) ? {1'b1, pat[i - 1]} : {1'b1, pat[i - 2]};
            check($sformatf("l20_tr%0d", i), 32'(tq[b + i]), 32'(e));
        end
        check("l20_done_once", 32'(done_cnt - d), 32'd1);

        // len=0: done on the second cycle after start, no panel activity
        b = tq.size(); d = done_cnt;
        start(0, 1'b0);
        check("l0_c1_done", 32'(done_o), 32'd0);
        check("l0_c1_busy", 32'(busy_o), 32'd1);
        @(negedge clk);
        check("l0_c2_done", 32'(done_o), 32'd1);
        check("l0_c2_busy", 32'(busy_o), 32'd0);
        repeat (3) @(negedge clk);
        check("l0_no_trans", 32'(tq.size() - b), 32'd0);
        check("l0_done_once", 32'(done_cnt - d), 32'd1);

        // start and write while busy are ignored
        b = tq.size(); d = done_cnt;
        start(8, 1'b0);
        wait_trans(b, 5);
        start_i = 1'b1; len_i = 6'd3; msg_we_i = 1'b1; msg_addr_i = 5'd6; msg_data_i = "z";
        @(negedge clk);
        start_i = 1'b0; msg_we_i = 1'b0;
        wait_done("ign", 2000);
        repeat (20) @(negedge clk);
        check("ign_count", 32'(tq.size() - b), 32'd8);
        for (int i = 0; i < 8; i++)
            check($sformatf("ign_ch%0d", i), 32'(tq[b + i]), 32'({1'b1, pat[i]}));
        check("ign_done_once", 32'(done_cnt - d), 32'd1);

        // reset mid-print aborts with no done, fresh start begins at character 0
        b = tq.size(); d = done_cnt;
        start(10, 1'b0);
        wait_trans(b, 3);
        #2 rst_ni = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy_o), 32'd0);
        check("rst_mid_e", 32'(lcd_e_o), 32'd0);
        check("rst_mid_enb", 32'(dut.enb_q), 32'd0);
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        repeat (30) @(negedge clk);
        check("rst_mid_no_done", 32'(done_cnt - d), 32'd0);
        b = tq.size(); d = done_cnt;
        start(4, 1'b0);
        wait_done("rst_re", 2000);
        check("rst_re_count", 32'(tq.size() - b), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("rst_re_ch%0d", i), 32'(tq[b + i]), 32'({1'b1, pat[i]}));

        // len 40 saturates to 32; one line jump, characters past 32 positions never wrap again
        b = tq.size(); d = done_cnt;
        start(40, 1'b0);
        wait_done("sat", 4000);
        check("sat_count", 32'(tq.size() - b), 32'd33);
        check("sat_first", 32'(tq[b]), 32'({1'b1, pat[0]}));
        check("sat_line2", 32'(tq[b + 16]), 32'h0C0);
        check("sat_ch16", 32'(tq[b + 17]), 32'({1'b1, pat[16]}));
        check("sat_last", 32'(tq[b + 32]), 32'({1'b1, pat[31]}));
        check("sat_done_once", 32'(done_cnt - d), 32'd1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/lcd_msg_writer.md
LCD_MSG_WRITER -- requirements
Module: lcd_msg_writer

Interface
REQ-001 Parameter MSG_LEN, default 32, message buffer depth in characters (1..32).
REQ-002 Parameter LINE_LEN, default 16, characters per display line before the line-2 jump.
REQ-003 Parameter CLEAR_ON_START, default 1, enables the optional clear-display command before each message.
REQ-004 clk_i  input  1  single clock; all logic rising-edge.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 msg_we_i  input  1  buffer write strobe.
REQ-007 msg_addr_i  input  $clog2(MSG_LEN)  buffer write address.
REQ-008 msg_data_i  input  8  ASCII character to store.
REQ-009 len_i  input  $clog2(MSG_LEN)+1  characters to print, sampled on start.
REQ-010 clr_i  input  1  request clear-display before printing, sampled on start; ignored when CLEAR_ON_START=0.
REQ-011 start_i  input  1  one-cycle start pulse.
REQ-012 busy_o  output  1  high from the cycle after an accepted start until done.
REQ-013 done_o  output  1  one-cycle pulse after the final character completes.
REQ-014 lcd_rs_o, lcd_e_o  output  1 each  LCD panel pins, driven by the lcd16x2 driver.
REQ-015 lcd_data_o  output  8  LCD panel data bus, driven by the lcd16x2 driver.

Function
REQ-016 The block SHALL instantiate lcd16x2 and drive its data_i, ops_i, enb_i; its rst_i SHALL be ~rst_ni.
REQ-017 Each driver transaction: in ISSUE, wait rdy=1, then present data/ops and set enb=1; in WAIT_ACK, wait rdy=0, then clear enb; in WAIT_RDY, wait rdy=1, then advance.
REQ-018 FSM states: IDLE, CLEAR, ISSUE, WAIT_ACK, WAIT_RDY, NEXT, FINISH.
REQ-019 IDLE: start_i=1 latches len_i and clr_i and zeroes the index. Next state: CLEAR if clr and CLEAR_ON_START, else FINISH if len=0, else ISSUE.
REQ-020 CLEAR SHALL issue command 0x01 with ops=OPS_CMD using the REQ-017 handshake, then go to ISSUE, or to FINISH if len=0.
REQ-021 ISSUE SHALL send buf[idx] with ops=OPS_DATA.
REQ-022 NEXT SHALL increment idx, then go to FINISH if idx=len. If idx=LINE_LEN, it SHALL first send command 0xC0 (ops=OPS_CMD) via the full handshake, then go to ISSUE. Otherwise it goes to ISSUE.
REQ-023 len_i greater than MSG_LEN SHALL be saturated to MSG_LEN.
REQ-024 Only one line jump per message; characters beyond 2*LINE_LEN SHALL still be sent without wrap.
REQ-025 FINISH SHALL pulse done_o for one cycle, drop busy_o, and return to IDLE.
REQ-026 start_i while busy_o=1 SHALL be ignored.
REQ-027 msg_we_i while busy_o=1 SHALL be ignored, so the buffer is stable during a print.
REQ-028 msg_we_i is accepted in IDLE, including in the same cycle as start_i; in that case the write lands before the first character is read.
REQ-029 enb SHALL never be high for two consecutive transactions without an intervening rdy=0 observation.

Reset
REQ-030 Asserting rst_ni low SHALL immediately force: state=IDLE, idx=0, enb=0, ops=OPS_CMD, data=0x00, busy_o=0, done_o=0.
REQ-031 Buffer contents are not reset.
REQ-032 Reset mid-print SHALL abort the print with no done_o pulse.
REQ-033 The driver is reset concurrently with the block.

Structure
REQ-034 Package lcd_pkg SHALL hold OPS_CMD=2'd0, OPS_DATA=2'd1, CMD_CLEAR=8'h01, CMD_LINE2=8'hC0, and the FSM state enum.
REQ-035 The sole sub-module is lcd16x2.
REQ-036 The buffer is inferred as distributed RAM.

Verification
REQ-037 Load "HELLO WORLD", len=11, clr=0, start -> driver sees 11 data transactions 0x48..0x44 in order; done_o pulses once.
REQ-038 len=20, clr=1 -> transaction sequence is 0x01 cmd, 16 data, 0xC0 cmd, 4 data; done_o pulses once.
REQ-039 len=0, clr=0 -> done_o pulses on the second cycle after start, with no enb activity.
REQ-040 Second start and msg_we_i at character 5 -> both are ignored; output matches the first message exactly.
REQ-041 rst_ni low at character 3 -> enb=0 and busy_o=0 immediately; no done_o; a fresh start after release prints from character 0.
REQ-042 Driver model holding rdy=1 for 50 cycles after enb -> FSM waits in WAIT_ACK; no duplicate transaction.
